serial_addsub_ctrl: RTL

Bit-serial add/subtract sequencer that drives a single full adder/subtractor (`fas`) bit cell, one operand bit per clock, LSB first. It sits directly upstream and downstream of the bit cell. It loads two N-bit operands and presents bit i on the cell's `a`/`b` inputs. It holds `a_ns` for the whole operation, closes the carry loop through a register (cell `cout` → `cin` on the next bit), and assembles the returned `s` bits into an N-bit result. Start/busy/done handshake toward the host.

---
 rtl/serial_addsub_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub sequencer around one fas bit cell, LSB first; result after N+1 cycles.
// No backpressure: start is taken in IDLE or on the DONE exit edge, otherwise dropped.
module serial_addsub_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_ns_in,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         fas_a,
  output logic         fas_b,
  output logic         fas_cin,
  output logic         fas_a_ns,
  input  logic         fas_s,
  input  logic         fas_cout,
  output logic [N-1:0] result,
  output logic         carry_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:1]  sh_a;
  logic [N-1:1]  sh_b;
  logic [CW-1:0] cnt;
  logic          carry;

  assign fas_cin   = carry;
  assign carry_out = carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      fas_a    <= 1'b0;
      fas_b    <= 1'b0;
      fas_a_ns <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Taking start on the DONE exit edge gives one operation per N+1 cycles.
          if (start) begin
            state    <= RUN;
            sh_a     <= op_a[N-1:1];
            sh_b     <= op_b[N-1:1];
            fas_a    <= op_a[0];
            fas_b    <= op_b[0];
            fas_a_ns <= a_ns_in;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result <= {fas_s, result[N-1:1]};
          carry  <= fas_cout;
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            fas_a <= sh_a[1];
            fas_b <= sh_b[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
